// File: rtl/memory_op_unit_if.sv
// rtl/memory_op_unit_if.sv - instruction, result and RAM/sys bus signal bundle for memory_op_unit
interface memory_op_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // upstream instruction handshake
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [3:0]        r1_op;
  logic [3:0]        r2_op;
  logic              proceed;

  // downstream result handshake
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] m1;
  logic [DATA_W-1:0] m2;
  logic [1:0]        err;

  // RAM bus
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  // sys bus
  logic              sys_req;
  logic              sys_we;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_wdata;
  logic              sys_ack;
  logic [DATA_W-1:0] sys_rdata;

  modport master (
    input  in_valid, r1, r2, a1, a2, r1_op, r2_op, proceed,
    output in_ready,
    output out_valid, m1, m2, err,
    input  out_ready,
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata,
    output sys_req, sys_we, sys_addr, sys_wdata,
    input  sys_ack, sys_rdata
  );

  modport slave (
    output in_valid, r1, r2, a1, a2, r1_op, r2_op, proceed,
    input  in_ready,
    input  out_valid, m1, m2, err,
    output out_ready,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata,
    input  sys_req, sys_we, sys_addr, sys_wdata,
    output sys_ack, sys_rdata
  );
endinterface

// File: rtl/memory_op_unit.sv
// rtl/memory_op_unit.sv - two-lane memory-operation stage with sequenced RAM/sys accesses and timeout
module memory_op_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  memory_op_unit_if.master  io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter wide enough to hold TIMEOUT-1; TIMEOUT=0 never compares.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t state;
  state_t state_next;
  logic   alive;

  // latched instruction
  logic [DATA_W-1:0] r1_q;
  logic [DATA_W-1:0] r2_q;
  logic [ADDR_W-1:0] a1_q;
  logic [ADDR_W-1:0] a2_q;
  logic [3:0]        op1_q;
  logic [3:0]        op2_q;

  // results
  logic [DATA_W-1:0] m1_q;
  logic [DATA_W-1:0] m2_q;
  logic [1:0]        err_q;

  logic [CW-1:0]     cnt;

  // last values presented on each bus, held while that bus is idle
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              sys_we_q;
  logic [ADDR_W-1:0] sys_addr_q;
  logic [DATA_W-1:0] sys_wdata_q;

  // current-lane decode
  logic              in_lane;
  logic              lane2;
  logic [3:0]        cur_op;
  logic [DATA_W-1:0] cur_self;
  logic [DATA_W-1:0] cur_other;
  logic [DATA_W-1:0] plain_m;
  logic              use_ram;
  logic              use_sys;
  logic              is_store;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] bus_addr;
  logic              ram_act;
  logic              sys_act;
  logic              bus_ack;
  logic              timed_out;
  logic [DATA_W-1:0] lane_m;
  logic              lane_done;
  logic              accept;

  // Decode the active lane's op into a bus choice, address and plain result.
  always_comb begin
    in_lane   = (state == LANE1) || (state == LANE2);
    lane2     = (state == LANE2);
    cur_op    = lane2 ? op2_q : op1_q;
    cur_self  = lane2 ? r2_q : r1_q;
    cur_other = lane2 ? r1_q : r2_q;
    use_ram   = 1'b0;
    use_sys   = 1'b0;
    is_store  = 1'b0;
    sel       = 2'd0;
    plain_m   = '0;
    case (cur_op)
      4'd1:                plain_m = cur_self;
      4'd2, 4'd3, 4'd4: begin
        use_ram = 1'b1;
        sel     = 2'(cur_op - 4'd2);
      end
      4'd5, 4'd6, 4'd7: begin
        use_ram  = 1'b1;
        is_store = 1'b1;
        sel      = 2'(cur_op - 4'd5);
      end
      4'd8, 4'd9, 4'd10: begin
        use_sys = 1'b1;
        sel     = 2'(cur_op - 4'd8);
      end
      4'd11, 4'd12, 4'd13: begin
        use_sys  = 1'b1;
        is_store = 1'b1;
        sel      = 2'(cur_op - 4'd11);
      end
      4'd14:               plain_m = cur_other;
      default:             plain_m = '0;
    endcase
    case (sel)
      2'd0:    bus_addr = a1_q;
      2'd1:    bus_addr = a2_q;
      default: bus_addr = ADDR_W'(cur_other);
    endcase
  end

  // Access completion: ack beats a timeout landing in the same cycle.
  always_comb begin
    ram_act   = in_lane && use_ram;
    sys_act   = in_lane && use_sys;
    bus_ack   = (ram_act && io.ram_ack) || (sys_act && io.sys_ack);
    timed_out = (TIMEOUT != 0) && (ram_act || sys_act) && !bus_ack && (cnt == TO_LAST);
    if (!(ram_act || sys_act))
      lane_m = plain_m;
    else if (is_store)
      lane_m = cur_self;
    else if (bus_ack)
      lane_m = ram_act ? io.ram_rdata : io.sys_rdata;
    else
      lane_m = '0;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    lane_done  = 1'b0;
    case (state)
      IDLE: begin
        if (alive && io.in_valid) begin
          accept     = 1'b1;
          state_next = LANE1;
        end
      end
      LANE1, LANE2: begin
        if (!(ram_act || sys_act) || bus_ack || timed_out) begin
          lane_done  = 1'b1;
          state_next = lane2 ? DONE : LANE2;
        end
      end
      DONE: begin
        if (io.out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Drive handshake and bus outputs; an idle bus repeats its last address/data.
  always_comb begin
    io.in_ready  = alive && (state == IDLE);
    io.out_valid = (state == DONE);
    io.m1        = m1_q;
    io.m2        = m2_q;
    io.err       = err_q;
    io.ram_req   = ram_act;
    io.ram_we    = ram_act ? is_store : ram_we_q;
    io.ram_addr  = ram_act ? bus_addr : ram_addr_q;
    io.ram_wdata = ram_act ? cur_self : ram_wdata_q;
    io.sys_req   = sys_act;
    io.sys_we    = sys_act ? is_store : sys_we_q;
    io.sys_addr  = sys_act ? bus_addr : sys_addr_q;
    io.sys_wdata = sys_act ? cur_self : sys_wdata_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive <= 1'b0;
    else      alive <= 1'b1;
  end

  // Capture the instruction on accept; proceed=0 turns both ops into no-ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_q  <= '0;
      r2_q  <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else if (accept) begin
      r1_q  <= io.r1;
      r2_q  <= io.r2;
      a1_q  <= io.a1;
      a2_q  <= io.a2;
      op1_q <= io.proceed ? io.r1_op : 4'd0;
      op2_q <= io.proceed ? io.r2_op : 4'd0;
    end
  end

  // Record each lane's result and timeout flag; flags clear on the output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_q  <= '0;
      m2_q  <= '0;
      err_q <= '0;
    end else if (lane_done) begin
      if (lane2) begin
        m2_q     <= lane_m;
        err_q[1] <= timed_out;
      end else begin
        m1_q     <= lane_m;
        err_q[0] <= timed_out;
      end
    end else if ((state == DONE) && io.out_ready) begin
      err_q <= '0;
    end
  end

  // Count request cycles that went unacknowledged in the current lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (!in_lane || lane_done)  cnt <= '0;
    else if (ram_act || sys_act)     cnt <= cnt + 1'b1;
  end

  // Remember what each bus last carried.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      sys_we_q    <= 1'b0;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
    end else begin
      if (ram_act) begin
        ram_we_q    <= is_store;
        ram_addr_q  <= bus_addr;
        ram_wdata_q <= cur_self;
      end
      if (sys_act) begin
        sys_we_q    <= is_store;
        sys_addr_q  <= bus_addr;
        sys_wdata_q <= cur_self;
      end
    end
  end

endmodule

// File: tb/tb_memory_op_unit.sv
// tb/tb_memory_op_unit.sv - directed and randomized checks of memory_op_unit against a lane-level model
`timescale 1ns/1ps
module tb_memory_op_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_op_unit_if #(.DATA_W(DW), .ADDR_W(AW)) io ();
  memory_op_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int checks   = 0;
  int failures = 0;

  // bus world: ack index per access on each bus (0 = never acks)
  int ram_lat = 1;
  int sys_lat = 1;
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] sys_mem [logic [31:0]];
  logic [31:0] ref_ram [logic [31:0]];
  logic [31:0] ref_sys [logic [31:0]];
  int ram_k = 0;
  int sys_k = 0;
  int ram_req_cyc = 0;
  int sys_req_cyc = 0;
  bit both_req = 0;
  logic ram_we_log [$];

  logic [31:0] obs_m1, obs_m2;
  logic [1:0]  obs_err;
  int          obs_lat;

  function automatic logic [31:0] bg(input logic [31:0] a, input bit sys);
    return sys ? (a ^ 32'h5A5A_0F0F) : (a ^ 32'hC3C3_1234);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus responders: ack in the lat-th request cycle of each access.
  always @(negedge clk) begin
    if (io.ram_req && io.sys_req) both_req = 1;
    if (io.ram_ack) ram_k = 0;
    io.ram_ack = 1'b0;
    if (io.ram_req) begin
      ram_k++;
      ram_req_cyc++;
      if (ram_lat != 0 && ram_k == ram_lat) begin
        io.ram_ack   = 1'b1;
        io.ram_rdata = ram_mem.exists(io.ram_addr) ? ram_mem[io.ram_addr] : bg(io.ram_addr, 0);
        ram_we_log.push_back(io.ram_we);
        if (io.ram_we) ram_mem[io.ram_addr] = io.ram_wdata;
      end else if (ram_k >= TO) begin
        ram_k = 0;
      end
    end else begin
      ram_k = 0;
    end
    if (io.sys_ack) sys_k = 0;
    io.sys_ack = 1'b0;
    if (io.sys_req) begin
      sys_k++;
      sys_req_cyc++;
      if (sys_lat != 0 && sys_k == sys_lat) begin
        io.sys_ack   = 1'b1;
        io.sys_rdata = sys_mem.exists(io.sys_addr) ? sys_mem[io.sys_addr] : bg(io.sys_addr, 1);
        if (io.sys_we) sys_mem[io.sys_addr] = io.sys_wdata;
      end else if (sys_k >= TO) begin
        sys_k = 0;
      end
    end else begin
      sys_k = 0;
    end
  end

  // Lane-level reference: result, error, extra latency and request cycles.
  task automatic model_lane(input logic [3:0] op, input logic [31:0] self, input logic [31:0] other,
                            input logic [31:0] a1, input logic [31:0] a2,
                            output logic [31:0] m, output logic e, output int extra,
                            inout int rq_ram, inout int rq_sys);
    int lat, idx;
    bit sys, store;
    logic [31:0] addr;
    m = 0; e = 0; extra = 0;
    if (op == 1) m = self;
    else if (op == 14) m = other;
    else if (op >= 2 && op <= 13) begin
      sys   = (op >= 8);
      store = (op >= 5 && op <= 7) || (op >= 11);
      idx   = (int'(op) - 2) % 3;
      addr  = (idx == 0) ? a1 : (idx == 1) ? a2 : other;
      lat   = sys ? sys_lat : ram_lat;
      if (lat != 0 && lat <= TO) begin
        extra = lat - 1;
        if (sys) rq_sys += lat; else rq_ram += lat;
        if (store) begin
          m = self;
          if (sys) ref_sys[addr] = self; else ref_ram[addr] = self;
        end else if (sys) begin
          m = ref_sys.exists(addr) ? ref_sys[addr] : bg(addr, 1);
        end else begin
          m = ref_ram.exists(addr) ? ref_ram[addr] : bg(addr, 0);
        end
      end else begin
        extra = TO - 1;
        if (sys) rq_sys += TO; else rq_ram += TO;
        e = 1;
        m = store ? self : 32'h0;
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] a1, input logic [31:0] a2,
                         input logic [3:0] o1, input logic [3:0] o2, input logic pr, input int hold);
    logic [3:0]  g1, g2;
    logic [31:0] e_m1, e_m2;
    logic        e_e1, e_e2;
    int x1, x2, n, lat;
    int erq = 0;
    int esq = 0;
    g1 = pr ? o1 : 4'd0;
    g2 = pr ? o2 : 4'd0;
    model_lane(g1, r1, r2, a1, a2, e_m1, e_e1, x1, erq, esq);
    model_lane(g2, r2, r1, a1, a2, e_m2, e_e2, x2, erq, esq);
    n = 0;
    while (io.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, ":in_ready"}, io.in_ready, 1);
    ram_req_cyc = 0; sys_req_cyc = 0; both_req = 0;
    io.r1 = r1; io.r2 = r2; io.a1 = a1; io.a2 = a2;
    io.r1_op = o1; io.r2_op = o2; io.proceed = pr; io.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.r1 = $urandom; io.r2 = $urandom; io.a1 = $urandom; io.a2 = $urandom;
    io.r1_op = 4'($urandom); io.r2_op = 4'($urandom); io.proceed = 1'($urandom);
    lat = 1;
    while (io.out_valid !== 1'b1 && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
    obs_m1 = io.m1; obs_m2 = io.m2; obs_err = io.err; obs_lat = lat;
    check({tag, ":latency"}, lat, 3 + x1 + x2);
    check({tag, ":m1"}, io.m1, e_m1);
    check({tag, ":m2"}, io.m2, e_m2);
    check({tag, ":err"}, io.err, {e_e2, e_e1});
    check({tag, ":ram_req_cycles"}, ram_req_cyc, erq);
    check({tag, ":sys_req_cycles"}, sys_req_cyc, esq);
    check({tag, ":one_req"}, both_req, 0);
    for (int h = 0; h < hold; h++) begin
      io.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, ":hold_valid"}, io.out_valid, 1);
      check({tag, ":hold_ready"}, io.in_ready, 0);
      check({tag, ":hold_out"}, {io.m1, io.m2, io.err}, {e_m1, e_m2, e_e2, e_e1});
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready = 1'b0;
    check({tag, ":post_valid"}, io.out_valid, 0);
    check({tag, ":post_err"}, io.err, 0);
    check({tag, ":post_in_ready"}, io.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [4];
    int lats [6];
    logic [31:0] rr1, rr2;
    int n;
    pool[0] = 32'h40; pool[1] = 32'h44; pool[2] = 32'h48; pool[3] = 32'h4C;
    lats[0] = 1; lats[1] = 2; lats[2] = 3; lats[3] = 16; lats[4] = 17; lats[5] = 0;

    io.in_valid = 0; io.out_ready = 0; io.proceed = 0;
    io.r1 = 0; io.r2 = 0; io.a1 = 0; io.a2 = 0; io.r1_op = 0; io.r2_op = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:in_ready", io.in_ready, 0);
    check("reset:out_valid", io.out_valid, 0);
    check("reset:err", io.err, 0);
    check("reset:req", {io.ram_req, io.sys_req}, 0);
    check("reset:m", {io.m1, io.m2}, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release:in_ready", io.in_ready, 1);

    // register move and lane swap, no bus traffic
    run_txn("t1", 32'h11, 32'h22, 32'h0, 32'h0, 4'd1, 4'd14, 1'b1, 0);
    check("t1:m1_const", obs_m1, 32'h11);
    check("t1:m2_const", obs_m2, 32'h11);
    check("t1:lat_const", obs_lat, 3);

    // proceed=0 squashes both ops
    run_txn("t2", 32'h1234, 32'h40, 32'h40, 32'h44, 4'd5, 4'd2, 1'b0, 0);
    check("t2:m_const", {obs_m1, obs_m2}, 64'h0);

    // store then load of the same RAM word, ack on the 2nd request cycle
    ram_lat = 2;
    ram_we_log.delete();
    run_txn("t3", 32'hDEAD, 32'h7, 32'h40, 32'h80, 4'd5, 4'd2, 1'b1, 0);
    check("t3:m2_const", obs_m2, 32'hDEAD);
    check("t3:we_count", ram_we_log.size(), 2);
    if (ram_we_log.size() == 2) begin
      check("t3:we_first", ram_we_log[0], 1);
      check("t3:we_second", ram_we_log[1], 0);
    end

    // sys load that never acks: lane1 times out, lane2 still runs
    sys_lat = 0;
    run_txn("t4", 32'h99, 32'h8, 32'h0, 32'h0, 4'd10, 4'd1, 1'b1, 0);
    check("t4:err_const", obs_err, 2'b01);
    check("t4:m1_const", obs_m1, 32'h0);
    check("t4:m2_const", obs_m2, 32'h8);
    sys_lat = 1;

    // ack on the final allowed cycle wins over the timeout; hold results 5 cycles
    ram_lat = 16;
    run_txn("t5", 32'h5, 32'h6, 32'h40, 32'h44, 4'd3, 4'd1, 1'b1, 5);
    check("t5:err_const", obs_err, 2'b00);
    ram_lat = 1;
    run_txn("t5b", 32'hA, 32'hB, 32'h0, 32'h0, 4'd14, 4'd1, 1'b1, 0);

    // reset in the middle of a RAM access
    ram_lat = 0;
    io.r1 = 32'h1; io.r2 = 32'h2; io.a1 = 32'h48; io.a2 = 32'h4C;
    io.r1_op = 4'd2; io.r2_op = 4'd1; io.proceed = 1'b1; io.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    n = 0;
    while (io.ram_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("t6:req_up", io.ram_req, 1);
    #2 rst = 1'b0;
    #1;
    check("t6:req_drop", io.ram_req, 0);
    check("t6:out_valid", io.out_valid, 0);
    check("t6:in_ready", io.in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ram_lat = 1;
    @(posedge clk);
    @(negedge clk);
    check("t6:in_ready_after", io.in_ready, 1);
    run_txn("t6b", 32'h3, 32'h4, 32'h48, 32'h4C, 4'd7, 4'd4, 1'b1, 0);

    // randomized instructions over a small address pool
    for (int i = 0; i < 30; i++) begin
      ram_lat = lats[$urandom_range(0, 5)];
      sys_lat = lats[$urandom_range(0, 5)];
      rr1 = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
      rr2 = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : $urandom;
      run_txn($sformatf("rnd%0d", i), rr1, rr2, pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
              $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
